serial_addsub_ctrl: RTL and testbench
=====================================

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter W, default 8, SHALL set the operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL be the request to begin one operation; it is sampled only when busy=0.
REQ-005 mode  input  1  SHALL select the operation: 0 = add (A+B), 1 = subtract (A-B, two's complement); it is captured with start.
REQ-006 a  input  W  SHALL be operand A, captured with start.
REQ-007 b  input  W  SHALL be operand B, captured with start.
REQ-008 busy  output  1  SHALL be high while an operation is in progress (RUN state).
REQ-009 done  output  1  SHALL be a one-cycle pulse marking that the result is valid.
REQ-010 sum  output  W  SHALL be the result of the last completed operation.
REQ-011 cout  output  1  SHALL be the final carry out (add: carry; subtract: 1 = no borrow).
REQ-012 ovf  output  1  SHALL be the signed overflow flag of the last completed operation.

Function
REQ-013 The block SHALL compute the result bit-serially, LSB first, one bit per RUN cycle, through exactly one 1-bit full adder.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 Transitions: IDLE--start-->RUN; RUN--bit counter = W-1-->DONE; DONE--start-->RUN; DONE--!start-->IDLE.
REQ-016 On start acceptance, the block SHALL load a and b into shift registers, clear the bit counter and the partial result, and set the carry register to mode.
REQ-017 Each RUN cycle SHALL apply full-adder inputs a_sh[0], b_sh[0] XOR mode and carry.
REQ-018 Each RUN cycle SHALL then shift the adder's sum bit into the MSB of the partial-result register, shift both operand registers right by one, store the adder's carry out, and increment the counter.
REQ-019 On the last RUN cycle, the block SHALL record the carry into the MSB (carry register before that cycle's add) for the overflow computation.
REQ-020 On the RUN->DONE edge, sum, cout and ovf SHALL be updated; ovf = carry into MSB XOR carry out of MSB.
REQ-021 sum, cout and ovf SHALL hold their values in every cycle other than the RUN->DONE edge, including across later starts, until the next completion.
REQ-022 Latency: with start accepted at edge k, done SHALL be high during the cycle after edge k+W, i.e. exactly W+1 edges after acceptance.
REQ-023 busy SHALL be high in RUN only and done SHALL be high in DONE only; both SHALL never be high together.
REQ-024 A start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 Changes to a, b or mode during RUN SHALL have no effect on the operation in progress.
REQ-026 A start asserted in DONE SHALL be accepted, giving back-to-back operations with no idle cycle; the done pulse still occurs.
REQ-027 The bit counter SHALL be $clog2(W) bits wide and SHALL never wrap within an operation.

Reset
REQ-028 When rst=1 at a clock edge, the FSM SHALL go to IDLE, with busy=0, done=0, sum=0, cout=0 and ovf=0.
REQ-029 At the same reset edge, the counter, the carry register, the shift registers and the partial result SHALL all be cleared.
REQ-030 rst SHALL take priority over start; a reset during RUN SHALL abort the operation with no done pulse.

Structure
REQ-031 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width SHALL live in a shared header/package for use by the adder-lab benches.
REQ-032 The 1-bit adder SHALL be the existing full_adder module, instantiated once; no other sub-module is required.

Verification
REQ-033 W=8, add, a=0x05, b=0x03: the bench SHALL see sum=0x08, cout=0, ovf=0, and done exactly 9 edges after start acceptance, with busy high for 8 cycles.
REQ-034 Add boundary cases SHALL give: 0xFF+0x01 -> sum=0x00, cout=1, ovf=0; 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
REQ-035 Subtract cases SHALL give: 0x05-0x07 -> sum=0xFE, cout=0, ovf=0; 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-036 Start asserted again mid-RUN with different operands SHALL be ignored; the first result and timing SHALL be unchanged.
REQ-037 Back-to-back: start held high across DONE SHALL produce a second op (0x10+0x20 -> 0x30) with done 9 edges later and no IDLE cycle.
REQ-038 rst asserted on the 4th RUN cycle SHALL give IDLE, all outputs 0 and no done pulse; a following start SHALL complete correctly.

Source files
------------

// File: rtl/serial_addsub_ctrl_pkg.sv
// serial_addsub_ctrl_pkg: shared state encodings and default width for the serial add/sub lab
package serial_addsub_ctrl_pkg;
    localparam int DEF_W = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_addsub_ctrl_full_adder.sv
// full_adder: 1-bit full adder
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial LSB-first adder/subtractor built around a single full adder
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int CW = $clog2(W);
    state_t state, state_nx;
    logic [W-1:0] a_sh, b_sh, res;
    logic [CW-1:0] cnt;
    logic carry, sub, fa_s, fa_co, accept, last;

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0] ^ sub),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    // next state and status decode; start is only honoured outside RUN
    always_comb begin
        busy     = state == RUN;
        done     = state == DONE;
        last     = busy && cnt == CW'(W - 1);
        accept   = !busy && start;
        state_nx = accept ? RUN : last ? DONE : busy ? RUN : IDLE;
    end

    // operand capture, one add per RUN cycle, result publish on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sub   <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            res   <= '0;
            cnt   <= '0;
            carry <= mode;
            sub   <= mode;
        end else if (busy) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= {fa_s, res[W-1:1]};
            carry <= fa_co;
            cnt   <= last ? cnt : cnt + 1'b1;
            if (last) begin
                sum  <= {fa_s, res[W-1:1]};
                cout <= fa_co;
                ovf  <= carry ^ fa_co;
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: directed and randomized checks against a cycle-level arithmetic model
module tb_serial_addsub_ctrl;
    localparam int W = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
    logic [W-1:0] a = '0, b = '0, sum;
    logic busy, done, cout, ovf;
    int vectors = 0, miscompares = 0;
    bit chk_on = 1'b0;

    serial_addsub_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // returns {cout, ovf, sum} from plain arithmetic
    function automatic logic [W+1:0] predict(input logic [W-1:0] x, y, input logic md);
        logic [W:0] f;
        logic [W-1:0] yy;
        logic v;
        yy = md ? ~y : y;
        f = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, md};
        v = (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]);
        return {f[W], v, f[W-1:0]};
    endfunction

    int rem = 0;
    logic m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic [W+1:0] pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            rem = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else begin
            m_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_done = 1'b1;
                    {m_cout, m_ovf, m_sum} = pend;
                end
            end else if (start) begin
                rem = W;
                pend = predict(a, b, mode);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            vectors++;
            if (busy !== (rem > 0) || done !== m_done || sum !== m_sum || cout !== m_cout || ovf !== m_ovf || (busy && done)) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got busy=%b done=%b sum=%h cout=%b ovf=%b, required busy=%b done=%b sum=%h cout=%b ovf=%b",
                         $time, busy, done, sum, cout, ovf, rem > 0, m_done, m_sum, m_cout, m_ovf);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic wait_done(input string nm, input bit mid, input int exp_busy);
        int j = 0, nb = 0;
        while (!done && j < 20) begin
            if (busy) nb++;
            if (mid && j == 2) begin
                start = 1'b1; a = 8'h33; b = 8'h44; mode = 1'b1;
            end else begin
                start = 1'b0; a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        chk({nm, "_latency_edges"}, j + 1, W + 1);
        chk({nm, "_busy_cycles"}, nb, exp_busy);
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] x, y, input logic md,
                         input logic [W-1:0] es, input logic ec, eo, input bit mid);
        @(negedge clk);
        start = 1'b1; a = x; b = y; mode = md;
        @(negedge clk);
        wait_done(nm, mid, W);
        chk({nm, "_sum"}, int'(sum), int'(es));
        chk({nm, "_cout"}, int'(cout), int'(ec));
        chk({nm, "_ovf"}, int'(ovf), int'(eo));
        chk({nm, "_model_sum"}, int'(m_sum), int'(es));
        chk({nm, "_model_flags"}, int'({m_cout, m_ovf}), int'({ec, eo}));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_outs", int'({sum, cout, ovf}), 0);
        rst = 1'b0;
        chk_on = 1'b1;

        do_op("add_5_3",    8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        do_op("add_ff_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("add_7f_01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        do_op("sub_05_07",  8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        do_op("sub_80_01",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        do_op("mid_ignore", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("outputs_hold_idle", int'({sum, cout, ovf}), int'({8'h08, 2'b00}));

        // back-to-back: start held high through DONE
        start = 1'b1; a = 8'h05; b = 8'h03; mode = 1'b0;
        @(negedge clk);
        begin
            int j = 0;
            a = 8'h10; b = 8'h20;
            while (!done && j < 20) begin
                @(negedge clk);
                j++;
            end
            chk("b2b_first_sum", int'(sum), 8'h08);
        end
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_idle_busy", int'(busy), 1);
        chk("b2b_outputs_held", int'(sum), 8'h08);
        wait_done("b2b_second", 1'b0, W);
        chk("b2b_second_sum", int'(sum), 8'h30);

        // reset on the 4th RUN cycle
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_outs", int'({sum, cout, ovf}), 0);
        begin
            int nd = 0;
            repeat (W + 3) begin
                @(negedge clk);
                if (done) nd++;
            end
            chk("abort_no_done", nd, 0);
        end
        do_op("after_abort", 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

        // randomized traffic, occasional resets, checked every cycle by the model
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = ($urandom % 3) == 0;
            a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
            rst = ($urandom % 97) == 0;
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (W + 3) @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
